// File: rtl/fp_add_pkg.sv
// Shared definitions for the pipelined floating-point adder: flag bit
// positions, operand classes and packing helpers for canonical results.
package fp_add_pkg;

   localparam int FLG_INVALID  = 2;
   localparam int FLG_OVERFLOW = 1;
   localparam int FLG_INEXACT  = 0;

   // Helpers build words up to this width; callers truncate to their format.
   localparam int PACK_W = 64;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_cls_e;

   // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
   function automatic logic [PACK_W-1:0] pack_qnan(input int exp_w, input int man_w);
      logic [PACK_W-1:0] v;
      v = ((PACK_W'(1) << exp_w) - PACK_W'(1)) << man_w;
      v = v | (PACK_W'(1) << (man_w - 1));
      return v;
   endfunction

   // Signed infinity: all-ones exponent, zero fraction.
   function automatic logic [PACK_W-1:0] pack_inf(input logic sign, input int exp_w, input int man_w);
      logic [PACK_W-1:0] v;
      v = ((PACK_W'(1) << exp_w) - PACK_W'(1)) << man_w;
      v = v | (PACK_W'(sign) << (exp_w + man_w));
      return v;
   endfunction

endpackage

// File: rtl/fp_add_pipe_lzc.sv
// Purely combinational leading-zero counter used by the normalise stage.
// An all-zero input reports W.
module fp_lzc #(
   parameter int W     = 15,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     i_data,
   output logic [CNT_W-1:0] o_count
);

   logic w_found;

   // Scan from the MSB down; the first set bit fixes the count.
   always_comb begin
      o_count = CNT_W'(W);
      w_found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!w_found && i_data[i]) begin
            o_count = CNT_W'(W - 1 - i);
            w_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_add_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with round-to-nearest-
// even, DAZ/FTZ, special-value handling and {invalid, overflow, inexact} flags.
// Stages: 1 unpack/compare, 2 align, 3 add/sub, 4 normalise/round/pack.
module fp_add_pipe
   import fp_add_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk73,
   input  logic         reset73,
   input  logic         in_valid73,
   output logic         in_ready73,
   input  logic         op_sub73,
   input  logic [W-1:0] number_a73,
   input  logic [W-1:0] number_b73,
   output logic         out_valid73,
   input  logic         out_ready73,
   output logic [W-1:0] result73,
   output logic [2:0]   flags73
);

   localparam int SIG_W = MAN_W + 1;   // hidden bit + fraction
   localparam int ALN_W = MAN_W + 4;   // significand + guard, round, sticky
   localparam int SUM_W = MAN_W + 5;   // aligned width + carry
   localparam int RND_W = MAN_W + 2;   // rounding carry + significand
   localparam int XW    = EXP_W + 2;   // exponent with headroom and sign
   localparam int LZ_W  = $clog2(SUM_W + 1);
   localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]  QNAN    = W'(pack_qnan(EXP_W, MAN_W));

   // Control that rides alongside the datapath; a special result decided in
   // stage 1 replaces the stage-4 arithmetic result without changing latency.
   typedef struct packed {
      logic             spec;
      logic [W-1:0]     spec_res;
      logic [2:0]       spec_flg;
      logic             sign;
      logic [EXP_W-1:0] exp;
   } side_t;

   function automatic fp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      fp_cls_e c;
      if (e == '0)          c = CLS_ZERO;   // subnormals flush to zero here
      else if (e != '1)     c = CLS_NORM;
      else if (f == '0)     c = CLS_INF;
      else if (f[MAN_W-1])  c = CLS_QNAN;
      else                  c = CLS_SNAN;
      return c;
   endfunction

   // Handshake: the whole pipe advances only when w_en = !out_valid73 | out_ready73,
   // which is also in_ready73. Operands transfer on in_valid73 & in_ready73,
   // results on out_valid73 & out_ready73; while w_en is low every stage holds
   // its data, valid and flags, so result73/flags73 stay stable under stall.
   logic w_en;

   logic         r1_v, r2_v, r3_v, r_v4;
   side_t        r1_side, r2_side, r3_side;
   logic         r1_eff_sub, r2_eff_sub;
   logic [SIG_W-1:0] r1_ml, r1_ms;
   logic [EXP_W-1:0] r1_diff;
   logic [ALN_W-1:0] r2_large, r2_small;
   logic [SUM_W-1:0] r3_sum;
   logic [W-1:0] r_result;
   logic [2:0]   r_flags;

   assign w_en        = !r_v4 | out_ready73;
   assign in_ready73  = w_en;
   assign out_valid73 = r_v4;
   assign result73    = r_result;
   assign flags73     = r_flags;

   // ---------------- Stage 1: unpack / compare ----------------
   logic             w_sa, w_sb, w_sl, w_ss, w_swap;
   logic [EXP_W-1:0] w_ea, w_eb, w_el, w_es;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic [SIG_W-1:0] w_ma, w_mb, w_ml, w_ms;
   fp_cls_e          w_ca, w_cb;
   side_t            w_side1;

   assign w_sa = number_a73[W-1];
   assign w_ea = number_a73[W-2 -: EXP_W];
   assign w_fa = number_a73[MAN_W-1:0];
   assign w_sb = number_b73[W-1] ^ op_sub73;
   assign w_eb = number_b73[W-2 -: EXP_W];
   assign w_fb = number_b73[MAN_W-1:0];
   assign w_ca = classify(w_ea, w_fa);
   assign w_cb = classify(w_eb, w_fb);
   assign w_ma = (w_ca == CLS_ZERO) ? '0 : {1'b1, w_fa};
   assign w_mb = (w_cb == CLS_ZERO) ? '0 : {1'b1, w_fb};

   // Larger magnitude goes to the "large" lane: exponent first, then significand.
   assign w_swap = {w_eb, w_mb} > {w_ea, w_ma};
   assign w_sl   = w_swap ? w_sb : w_sa;
   assign w_ss   = w_swap ? w_sa : w_sb;
   assign w_el   = w_swap ? w_eb : w_ea;
   assign w_es   = w_swap ? w_ea : w_eb;
   assign w_ml   = w_swap ? w_mb : w_ma;
   assign w_ms   = w_swap ? w_ma : w_mb;

   // Resolve special operands in priority order: NaN, Inf-Inf, Inf, zeros.
   always_comb begin
      w_side1          = '0;
      w_side1.sign     = w_sl;
      w_side1.exp      = w_el;
      if (w_ca == CLS_QNAN || w_ca == CLS_SNAN || w_cb == CLS_QNAN || w_cb == CLS_SNAN) begin
         w_side1.spec     = 1'b1;
         w_side1.spec_res = QNAN;
         w_side1.spec_flg[FLG_INVALID] = (w_ca == CLS_SNAN) || (w_cb == CLS_SNAN);
      end else if (w_ca == CLS_INF && w_cb == CLS_INF && w_sa != w_sb) begin
         w_side1.spec     = 1'b1;
         w_side1.spec_res = QNAN;
         w_side1.spec_flg[FLG_INVALID] = 1'b1;
      end else if (w_ca == CLS_INF) begin
         w_side1.spec     = 1'b1;
         w_side1.spec_res = W'(pack_inf(w_sa, EXP_W, MAN_W));
      end else if (w_cb == CLS_INF) begin
         w_side1.spec     = 1'b1;
         w_side1.spec_res = W'(pack_inf(w_sb, EXP_W, MAN_W));
      end else if (w_ca == CLS_ZERO && w_cb == CLS_ZERO) begin
         w_side1.spec     = 1'b1;
         w_side1.spec_res = {w_sa & w_sb, {(W-1){1'b0}}};
      end else if (w_ca == CLS_ZERO) begin
         w_side1.spec     = 1'b1;
         w_side1.spec_res = {w_sb, w_eb, w_fb};
      end else if (w_cb == CLS_ZERO) begin
         w_side1.spec     = 1'b1;
         w_side1.spec_res = {w_sa, w_ea, w_fa};
      end
   end

   // Stage 1 register: classified, ordered operands.
   always_ff @(posedge clk73 or negedge reset73) begin
      if (!reset73) begin
         r1_v       <= 1'b0;
         r1_side    <= '0;
         r1_eff_sub <= 1'b0;
         r1_ml      <= '0;
         r1_ms      <= '0;
         r1_diff    <= '0;
      end else if (w_en) begin
         r1_v       <= in_valid73;
         r1_side    <= w_side1;
         r1_eff_sub <= w_sl ^ w_ss;
         r1_ml      <= w_ml;
         r1_ms      <= w_ms;
         r1_diff    <= w_el - w_es;
      end
   end

   // ---------------- Stage 2: align ----------------
   int                 w_shamt;
   logic [2*ALN_W-1:0] w_wide;
   logic [ALN_W-1:0]   w_small;

   // Shift the small significand into a double-width field; everything that
   // lands in the lower half was shifted out and folds into sticky. Clamping
   // the shift keeps all lost bits inside that lower half.
   always_comb begin
      w_shamt = (int'(r1_diff) > ALN_W) ? ALN_W : int'(r1_diff);
      w_wide  = {r1_ms, 3'b000, {ALN_W{1'b0}}} >> w_shamt;
      w_small = {w_wide[2*ALN_W-1:ALN_W+1], w_wide[ALN_W] | (|w_wide[ALN_W-1:0])};
   end

   // Stage 2 register: aligned significands.
   always_ff @(posedge clk73 or negedge reset73) begin
      if (!reset73) begin
         r2_v       <= 1'b0;
         r2_side    <= '0;
         r2_eff_sub <= 1'b0;
         r2_large   <= '0;
         r2_small   <= '0;
      end else if (w_en) begin
         r2_v       <= r1_v;
         r2_side    <= r1_side;
         r2_eff_sub <= r1_eff_sub;
         r2_large   <= {r1_ml, 3'b000};
         r2_small   <= w_small;
      end
   end

   // ---------------- Stage 3: add / subtract ----------------
   logic [SUM_W-1:0] w_sum;

   // Large minus small never goes negative thanks to the stage-1 ordering.
   assign w_sum = r2_eff_sub ? ({1'b0, r2_large} - {1'b0, r2_small})
                             : ({1'b0, r2_large} + {1'b0, r2_small});

   // Stage 3 register: raw sum with carry.
   always_ff @(posedge clk73 or negedge reset73) begin
      if (!reset73) begin
         r3_v    <= 1'b0;
         r3_side <= '0;
         r3_sum  <= '0;
      end else if (w_en) begin
         r3_v    <= r2_v;
         r3_side <= r2_side;
         r3_sum  <= w_sum;
      end
   end

   // ---------------- Stage 4: normalise / round / pack ----------------
   logic [LZ_W-1:0]  w_lz, w_lsh;
   logic [SUM_W-1:0] w_norm;
   logic [XW-1:0]    w_exp_n, w_exp_f;
   logic [RND_W-1:0] w_rnd;
   logic [MAN_W-1:0] w_frac_f;
   logic             w_g, w_r, w_st, w_rup, w_ovf, w_ftz;
   logic [W-1:0]     w_res;
   logic [2:0]       w_flg;

   fp_lzc #(.W(SUM_W)) u_lzc (
      .i_data  (r3_sum),
      .o_count (w_lz)
   );

   // The carry bit is always zero on the left-shift path, so one zero is expected.
   assign w_lsh = w_lz - LZ_W'(1);

   // Normalise, round to nearest even, then choose Inf / FTZ / normal / special.
   always_comb begin
      w_norm  = '0;
      w_exp_n = '0;
      if (r3_sum[SUM_W-1]) begin
         w_norm  = {1'b0, r3_sum[SUM_W-1:2], r3_sum[1] | r3_sum[0]};
         w_exp_n = XW'(r3_side.exp) + XW'(1);
      end else begin
         w_norm  = r3_sum << w_lsh;
         w_exp_n = XW'(r3_side.exp) - XW'(w_lsh);
      end
      w_g      = w_norm[2];
      w_r      = w_norm[1];
      w_st     = w_norm[0];
      w_rup    = w_g & (w_r | w_st | w_norm[3]);
      w_rnd    = {1'b0, w_norm[MAN_W+3:3]} + RND_W'(w_rup);
      w_exp_f  = w_rnd[RND_W-1] ? (w_exp_n + XW'(1)) : w_exp_n;
      w_frac_f = w_rnd[RND_W-1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
      w_ovf    = !w_exp_f[XW-1] && (w_exp_f >= EXP_MAX);
      w_ftz    = w_exp_f[XW-1] || (w_exp_f == '0);

      w_res = '0;
      w_flg = '0;
      if (r3_side.spec) begin
         w_res = r3_side.spec_res;
         w_flg = r3_side.spec_flg;
      end else if (r3_sum == '0) begin
         w_res = '0;
      end else if (w_ovf) begin
         w_res = W'(pack_inf(r3_side.sign, EXP_W, MAN_W));
         w_flg[FLG_OVERFLOW] = 1'b1;
         w_flg[FLG_INEXACT]  = 1'b1;
      end else if (w_ftz) begin
         w_res = {r3_side.sign, {(W-1){1'b0}}};
         w_flg[FLG_INEXACT] = 1'b1;
      end else begin
         w_res = {r3_side.sign, w_exp_f[EXP_W-1:0], w_frac_f};
         w_flg[FLG_INEXACT] = w_g | w_r | w_st;
      end
   end

   // Stage 4 register: packed result presented to the consumer.
   always_ff @(posedge clk73 or negedge reset73) begin
      if (!reset73) begin
         r_v4     <= 1'b0;
         r_result <= '0;
         r_flags  <= '0;
      end else if (w_en) begin
         r_v4     <= r3_v;
         r_result <= w_res;
         r_flags  <= w_flg;
      end
   end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe at half precision: hand-computed vectors,
// latency, stall/backpressure stream and mid-stream asynchronous reset.
module tb_fp_add_pipe;

   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int W     = 16;

   logic         clk73;
   logic         reset73;
   logic         in_valid73;
   logic         in_ready73;
   logic         op_sub73;
   logic [W-1:0] number_a73;
   logic [W-1:0] number_b73;
   logic         out_valid73;
   logic         out_ready73;
   logic [W-1:0] result73;
   logic [2:0]   flags73;

   int n_checks = 0;
   int n_errors = 0;
   int n_recv   = 0;

   // Expected {flags, result} in issue order.
   logic [31:0] exp_q[$];

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] res;
      logic [2:0]  flg;
   } vec_t;
   vec_t vecs[$];

   fp_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk73       (clk73),
      .reset73     (reset73),
      .in_valid73  (in_valid73),
      .in_ready73  (in_ready73),
      .op_sub73    (op_sub73),
      .number_a73  (number_a73),
      .number_b73  (number_b73),
      .out_valid73 (out_valid73),
      .out_ready73 (out_ready73),
      .result73    (result73),
      .flags73     (flags73)
   );

   // Clock
   initial begin
      clk73 = 1'b0;
      forever #5 clk73 = ~clk73;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic add_vec(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic [15:0] res, input logic [2:0] flg);
      vec_t v;
      v.a = a; v.b = b; v.sub = sub; v.res = res; v.flg = flg;
      vecs.push_back(v);
   endtask

   task automatic drive_vec(input int idx);
      number_a73 = vecs[idx].a;
      number_b73 = vecs[idx].b;
      op_sub73   = vecs[idx].sub;
   endtask

   task automatic push_exp(input int idx);
      exp_q.push_back({13'd0, vecs[idx].flg, vecs[idx].res});
   endtask

   // Single operation on an empty pipe; measures accept-to-valid latency.
   task automatic run_single(input int idx);
      int lat;
      bit seen;
      drive_vec(idx);
      push_exp(idx);
      in_valid73 = 1'b1;
      #1;
      check("in_ready_idle", 32'(in_ready73), 32'd1);
      @(posedge clk73); #1;
      in_valid73 = 1'b0;
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 12) begin
         if (out_valid73) seen = 1'b1;
         else begin
            @(posedge clk73); #1;
            lat++;
         end
      end
      check($sformatf("latency_v%0d", idx), 32'(lat), 32'd4);
      @(posedge clk73); #1;
   endtask

   // Scoreboard: compare every presented result; pop only when it transfers.
   always @(negedge clk73) begin
      if (reset73 && out_valid73) begin
         check("out_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            check("result_flags", {13'd0, flags73, result73}, exp_q[0]);
            if (out_ready73) begin
               void'(exp_q.pop_front());
               n_recv++;
            end
         end
      end
   end

   // Global time bound
   initial begin
      #1000000;
      n_errors++;
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1, "timeout");
   end

   initial begin
      int sent;
      int base;
      reset73     = 1'b1;
      in_valid73  = 1'b0;
      op_sub73    = 1'b0;
      number_a73  = '0;
      number_b73  = '0;
      out_ready73 = 1'b1;

      //               A        B        sub   result   {inv,ovf,inx}
      add_vec(16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000);  // 1 + 2
      add_vec(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000);  // exact cancellation
      add_vec(16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000);  // -0 + -0
      add_vec(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b001);  // tie, stays even
      add_vec(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b001);  // tie, rounds to even
      add_vec(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b011);  // overflow
      add_vec(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b100);  // Inf - Inf
      add_vec(16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 3'b100);  // sNaN input
      add_vec(16'h4000, 16'h3C00, 1'b1, 16'h3C00, 3'b000);  // 2 - 1
      add_vec(16'h0000, 16'h3C00, 1'b1, 16'hBC00, 3'b000);  // 0 - 1 passthrough
      add_vec(16'h3C00, 16'h7E00, 1'b0, 16'h7E00, 3'b000);  // qNaN input
      add_vec(16'h0001, 16'h3C00, 1'b0, 16'h3C00, 3'b000);  // subnormal as zero
      add_vec(16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b001);  // underflow flush
      add_vec(16'hC000, 16'h3C00, 1'b0, 16'hBC00, 3'b000);  // -2 + 1
      add_vec(16'h3C00, 16'h1001, 1'b0, 16'h3C01, 3'b001);  // above half, rounds up
      add_vec(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000);  // carry out
      add_vec(16'hFC00, 16'h3C00, 1'b1, 16'hFC00, 3'b000);  // -Inf - 1

      // Reset
      #2 reset73 = 1'b0;
      repeat (2) @(posedge clk73);
      #1;
      check("rst_out_valid", 32'(out_valid73), 32'd0);
      check("rst_result", 32'(result73), 32'd0);
      check("rst_flags", 32'(flags73), 32'd0);
      reset73 = 1'b1;
      @(posedge clk73); #1;
      check("rel_in_ready", 32'(in_ready73), 32'd1);
      check("rel_out_valid", 32'(out_valid73), 32'd0);

      // Directed singles
      for (int i = 0; i < vecs.size(); i++) run_single(i);
      check("singles_drained", 32'(exp_q.size()), 32'd0);

      // Back-to-back stream with out_ready73 low on cycles 6..9
      base = n_recv;
      sent = 0;
      for (int cyc = 0; cyc < 40 && (sent < 8 || exp_q.size() > 0); cyc++) begin
         out_ready73 = !(cyc >= 6 && cyc <= 9);
         if (sent < 8) begin
            drive_vec(sent);
            in_valid73 = 1'b1;
         end else begin
            in_valid73 = 1'b0;
         end
         #1;
         if (cyc < 12) check($sformatf("in_ready_c%0d", cyc), 32'(in_ready73),
                             (cyc >= 6 && cyc <= 9) ? 32'd0 : 32'd1);
         if (cyc >= 6 && cyc <= 9) check($sformatf("stall_valid_c%0d", cyc), 32'(out_valid73), 32'd1);
         if (in_valid73 && in_ready73) begin
            push_exp(sent);
            sent++;
         end
         @(posedge clk73); #1;
      end
      in_valid73  = 1'b0;
      out_ready73 = 1'b1;
      check("stream_sent", 32'(sent), 32'd8);
      check("stream_recv", 32'(n_recv - base), 32'd8);
      check("stream_drained", 32'(exp_q.size()), 32'd0);

      // Mid-stream reset with three pairs in flight
      for (int i = 0; i < 3; i++) begin
         drive_vec(i);
         in_valid73 = 1'b1;
         #1;
         if (in_ready73) push_exp(i);
         @(posedge clk73); #1;
      end
      in_valid73 = 1'b0;
      @(posedge clk73); #1;
      check("pre_rst_valid", 32'(out_valid73), 32'd1);
      reset73 = 1'b0;
      exp_q.delete();
      #1;
      check("async_rst_valid", 32'(out_valid73), 32'd0);
      check("async_rst_result", 32'(result73), 32'd0);
      check("async_rst_flags", 32'(flags73), 32'd0);
      repeat (2) @(posedge clk73);
      #1 reset73 = 1'b1;
      @(posedge clk73); #1;
      check("rel2_in_ready", 32'(in_ready73), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("no_stale_c%0d", i), 32'(out_valid73), 32'd0);
         @(posedge clk73); #1;
      end
      run_single(5);
      check("final_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
